keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Row-scanned key matrix with per-key frame debouncing and a show-ahead
// press/release event FIFO with a sticky overflow flag.
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 100,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           gclk,
  input  logic                           greset,
  input  logic                           enable,
  output logic [ROWS-1:0]                key_y,
  input  logic [COLS-1:0]                key_x,
  output logic [ROWS*COLS-1:0]           key_state,
  output logic                           any_pressed,
  output logic                           evt_valid,
  input  logic                           evt_ready,
  output logic [$clog2(ROWS*COLS)-1:0]   evt_code,
  output logic                           evt_press,
  output logic                           overflow,
  input  logic                           overflow_clr
);

  localparam int N     = ROWS * COLS;
  localparam int CW    = $clog2(N);
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int RW    = $clog2(ROWS);
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = 4;

  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

  logic [DW-1:0]    dwell;
  logic [RW-1:0]    row_ptr;

  logic [COLS-1:0]  row_buf_p0;
  logic [RW-1:0]    row_p0;
  logic             vld_p0;

  logic [CNT_W-1:0] deb_cnt [N];

  logic             eval_en;
  logic [CW-1:0]    eval_idx;
  logic             eval_smp;
  logic             cur_state;
  logic [CNT_W-1:0] cur_cnt;
  logic             cnt_hit;
  logic             push;
  logic             push_press;

  logic [CW:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      fifo_cnt;
  logic             fifo_full;
  logic             pop;
  logic             do_push;

  always_ff @(posedge gclk or posedge greset) begin
    if (greset) begin
      dwell   <= '0;
      row_ptr <= '0;
      vld_p0  <= 1'b0;
    end else if (!enable) begin
      dwell   <= '0;
      row_ptr <= '0;
      vld_p0  <= 1'b0;
    end else if (dwell == DWELL_LAST) begin
      dwell   <= '0;
      row_ptr <= (row_ptr == ROW_LAST) ? '0 : row_ptr + 1'b1;
      vld_p0  <= 1'b1;
    end else begin
      dwell   <= dwell + 1'b1;
    end
  end

  // Stage p0: last-dwell row sample, evaluated during the next row's first COLS cycles
  always_ff @(posedge gclk) begin
    if (enable && dwell == DWELL_LAST) begin
      row_buf_p0 <= key_x;
      row_p0     <= row_ptr;
    end
  end

  always_comb begin
    key_y = '0;
    for (int r = 0; r < ROWS; r++) begin
      key_y[r] = enable && (int'(row_ptr) == r);
    end
  end

  always_comb begin
    eval_en  = enable && vld_p0 && (int'(dwell) < COLS);
    eval_idx = CW'(int'(row_p0) * COLS + int'(dwell));
    eval_smp = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (int'(dwell) == c) eval_smp = row_buf_p0[c];
    end
    cur_state = 1'b0;
    cur_cnt   = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(eval_idx) == i) begin
        cur_state = key_state[i];
        cur_cnt   = deb_cnt[i];
      end
    end
    cnt_hit    = (int'(cur_cnt) + 1 == DEBOUNCE);
    push       = eval_en && (eval_smp != cur_state) && cnt_hit;
    push_press = ~cur_state;
  end

  always_ff @(posedge gclk or posedge greset) begin
    if (greset) begin
      key_state <= '0;
      for (int i = 0; i < N; i++) deb_cnt[i] <= '0;
    end else if (!enable) begin
      for (int i = 0; i < N; i++) deb_cnt[i] <= '0;
    end else if (eval_en) begin
      for (int i = 0; i < N; i++) begin
        if (int'(eval_idx) == i) begin
          if (eval_smp == cur_state) begin
            deb_cnt[i] <= '0;
          end else if (cnt_hit) begin
            deb_cnt[i]   <= '0;
            key_state[i] <= ~cur_state;
          end else begin
            deb_cnt[i] <= cur_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign any_pressed = |key_state;

  // Event FIFO: a pop frees the slot that a simultaneous push into a full FIFO needs
  assign evt_valid            = (fifo_cnt != '0);
  assign fifo_full            = (fifo_cnt == FIFO_FULL);
  assign pop                  = evt_valid && evt_ready;
  assign do_push              = push && (!fifo_full || pop);
  assign {evt_press, evt_code} = fifo_mem[rd_ptr];

  always_ff @(posedge gclk) begin
    if (do_push) fifo_mem[wr_ptr] <= {push_press, eval_idx};
  end

  always_ff @(posedge gclk or posedge greset) begin
    if (greset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push && !do_push)  overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, cycle-level reference model,
// a debounce vector table, directed FIFO/reset/enable sequences and random stimulus.
module tb_keypad_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int SD    = 8;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;
  localparam int N     = ROWS * COLS;
  localparam int FRAME = ROWS * SD;
  localparam int LAT   = (DEB + 1) * ROWS * SD + COLS;

  logic           gclk = 1'b0;
  logic           greset;
  logic           enable;
  logic [ROWS-1:0] key_y;
  logic [COLS-1:0] key_x;
  logic [N-1:0]   key_state;
  logic           any_pressed;
  logic           evt_valid;
  logic           evt_ready;
  logic [3:0]     evt_code;
  logic           evt_press;
  logic           overflow;
  logic           overflow_clr;

  logic [N-1:0]   pressed;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .gclk(gclk), .greset(greset), .enable(enable), .key_y(key_y), .key_x(key_x),
    .key_state(key_state), .any_pressed(any_pressed), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_code(evt_code), .evt_press(evt_press),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 gclk = ~gclk;

  // Physical matrix: a closed key connects its driven row to its column.
  always_comb begin
    key_x = '0;
    for (int r = 0; r < ROWS; r++)
      if (key_y[r]) key_x = key_x | pressed[r*COLS +: COLS];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scan position is a pure function of cycles since scan start.
  typedef struct { int code; bit press; } evt_t;
  evt_t mq[$];
  int   mt;
  bit   mstate [N];
  int   mcnt   [N];
  bit   msmp   [COLS];
  int   msmp_row;
  bit   msmp_vld;
  bit   movf;

  always @(posedge gclk) begin
    bit   m_pop, m_push, m_full, m_drop;
    int   d, r, k;
    evt_t e;
    if (greset) begin
      mt = 0; msmp_vld = 0; movf = 0;
      for (int i = 0; i < N; i++) begin mstate[i] = 0; mcnt[i] = 0; end
      mq.delete();
    end else begin
      m_pop  = evt_ready && (mq.size() > 0);
      m_push = 0;
      m_drop = 0;
      e = '{0, 0};
      if (!enable) begin
        mt = 0; msmp_vld = 0;
        for (int i = 0; i < N; i++) mcnt[i] = 0;
      end else begin
        d = mt % SD;
        r = (mt / SD) % ROWS;
        if (msmp_vld && d < COLS) begin
          k = msmp_row * COLS + d;
          if (msmp[d] == mstate[k]) mcnt[k] = 0;
          else begin
            mcnt[k]++;
            if (mcnt[k] == DEB) begin
              mstate[k] = !mstate[k];
              mcnt[k] = 0;
              m_push = 1;
              e = '{k, mstate[k]};
            end
          end
        end
        if (d == SD - 1) begin
          for (int c = 0; c < COLS; c++) msmp[c] = pressed[r*COLS + c];
          msmp_row = r;
          msmp_vld = 1;
        end
        mt++;
      end
      m_full = (mq.size() == DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (!m_full || m_pop) mq.push_back(e);
        else m_drop = 1;
      end
      if (m_drop) movf = 1;
      else if (overflow_clr) movf = 0;
    end
  end

  function automatic logic [N-1:0] model_state();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = mstate[i];
    return v;
  endfunction

  function automatic bit model_push_next();
    int d, k;
    if (greset || !enable || !msmp_vld) return 0;
    d = mt % SD;
    if (d >= COLS) return 0;
    k = msmp_row * COLS + d;
    return (msmp[d] != mstate[k]) && (mcnt[k] + 1 == DEB);
  endfunction

  always @(negedge gclk) begin
    if (chk_en) begin
      check("m_key_y", 32'(key_y), enable ? 32'(1 << ((mt / SD) % ROWS)) : 32'd0);
      check("m_key_state", 32'(key_state), 32'(model_state()));
      check("m_any_pressed", 32'(any_pressed), 32'(model_state() != 0));
      check("m_evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("m_evt_code", 32'(evt_code), 32'(mq[0].code));
        check("m_evt_press", 32'(evt_press), 32'(mq[0].press));
      end
      check("m_overflow", 32'(overflow), 32'(movf));
    end
  end

  task automatic tick();
    @(negedge gclk);
    #1;
  endtask

  task automatic do_reset();
    greset = 1'b1;
    tick();
    tick();
    greset = 1'b0;
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic wait_evt(input string name);
    for (int i = 0; i < LAT + 8 && !evt_valid; i++) tick();
    check(name, 32'(evt_valid), 32'd1);
  endtask

  typedef struct {
    int key;
    int frames;
    bit exp_state;
  } vec_t;

  vec_t vecs [5];

  initial begin
    greset = 1'b1; enable = 1'b1; evt_ready = 1'b0; overflow_clr = 1'b0; pressed = '0;
    tick();
    tick();
    chk_en = 1;
    check("rst_key_y", 32'(key_y), 32'h1);
    check("rst_key_state", 32'(key_state), 32'h0);
    check("rst_evt_valid", 32'(evt_valid), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    greset = 1'b0;
    for (int r = 1; r <= ROWS; r++) begin
      repeat (SD) tick();
      check("row_cycle", 32'(key_y), 32'(1 << (r % ROWS)));
    end

    vecs[0] = '{9, 3, 1'b1};
    vecs[1] = '{5, 2, 1'b0};
    vecs[2] = '{0, 1, 1'b0};
    vecs[3] = '{15, 3, 1'b1};
    vecs[4] = '{6, 4, 1'b1};
    foreach (vecs[v]) begin
      pressed = '0;
      do_reset();
      pressed[vecs[v].key] = 1'b1;
      repeat (vecs[v].frames * FRAME) tick();
      pressed = '0;
      repeat (2 * FRAME) tick();
      check("vec_state", 32'(key_state[vecs[v].key]), 32'(vecs[v].exp_state));
      check("vec_evt_valid", 32'(evt_valid), 32'(vecs[v].exp_state));
      if (vecs[v].exp_state) begin
        check("vec_evt_code", 32'(evt_code), 32'(vecs[v].key));
        check("vec_evt_press", 32'(evt_press), 32'd1);
      end
    end

    // Press then release key 9, each within the latency bound
    do_reset();
    pressed[9] = 1'b1;
    wait_evt("press_timeout");
    check("press_code", 32'(evt_code), 32'd9);
    check("press_type", 32'(evt_press), 32'd1);
    check("press_state", 32'(key_state[9]), 32'd1);
    pop_one();
    pressed[9] = 1'b0;
    wait_evt("release_timeout");
    check("release_code", 32'(evt_code), 32'd9);
    check("release_type", 32'(evt_press), 32'd0);
    check("release_state", 32'(key_state[9]), 32'd0);
    pop_one();

    // Overflow: five presses into a four-entry FIFO
    do_reset();
    pressed = 16'h001F;
    repeat (5 * FRAME) tick();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_state", 32'(key_state), 32'h001F);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_valid", 32'(evt_valid), 32'd1);
      check("ovf_order", 32'(evt_code), 32'(i));
      pop_one();
    end
    check("ovf_drained", 32'(evt_valid), 32'd0);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with a pop on the push cycle: nothing dropped
    pressed = '0;
    do_reset();
    pressed = 16'h001F;
    for (int i = 0; i < 6 * FRAME && !(mq.size() == DEPTH && model_push_next()); i++) tick();
    check("full_push_window", 32'(mq.size() == DEPTH && model_push_next()), 32'd1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("full_pp_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= DEPTH; i++) begin
      check("full_pp_valid", 32'(evt_valid), 32'd1);
      check("full_pp_code", 32'(evt_code), 32'(i));
      pop_one();
    end
    check("full_pp_empty", 32'(evt_valid), 32'd0);

    // Reset during row 2 with two events pending
    pressed = '0;
    do_reset();
    pressed = 16'h0003;
    repeat (3 * FRAME) tick();
    for (int i = 0; i < FRAME && key_y != 4'b0100; i++) tick();
    check("mid_row2", 32'(key_y), 32'h4);
    check("mid_pending", 32'(evt_valid), 32'd1);
    greset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(evt_valid), 32'd0);
    check("mid_rst_key_y", 32'(key_y), 32'h1);
    check("mid_rst_state", 32'(key_state), 32'h0);
    pressed = '0;
    tick();
    tick();
    greset = 1'b0;

    // Disable mid-debounce discards progress
    pressed[9] = 1'b1;
    repeat (2 * FRAME) tick();
    enable = 1'b0;
    #1;
    check("dis_key_y", 32'(key_y), 32'h0);
    repeat (FRAME) tick();
    pressed = '0;
    enable = 1'b1;
    repeat (4 * FRAME) tick();
    check("dis_no_evt", 32'(evt_valid), 32'd0);
    check("dis_state", 32'(key_state), 32'h0);

    // Random keys, consumer, enable and reset activity
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(99) == 0) pressed[$urandom_range(N-1)] ^= 1'b1;
      evt_ready    = ($urandom_range(3) == 0);
      overflow_clr = ($urandom_range(49) == 0);
      if (enable && $urandom_range(499) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(19) == 0) enable = 1'b1;
      greset = ($urandom_range(1999) == 0);
      tick();
    end
    greset = 1'b0;
    enable = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
